// File: rtl/matrix_frame_ctrl.sv
// Double-buffered frame controller for an 8x8 LED matrix scan driver.
// Rows are written into a back buffer, and a commit copies it to the displayed
// front buffer only on a scan-frame boundary so the driver never shows a torn
// frame. The block also owns the driver output enable and a frame-counted blink.
//
// Ports:
//   clock          system clock, rising edge
//   reset          synchronous active-high reset
//   wr_valid       row write request
//   wr_ready       back buffer accepts writes (low while a commit is pending)
//   wr_row         target row index 0..7
//   wr_data        row bits, bit c is column c
//   commit         single-cycle pulse requesting a back-to-front copy
//   commit_pending commit accepted but not yet applied
//   swap_done      one-cycle pulse the cycle after the copy
//   enable         display on
//   blink_en       enable blinking
//   data           frame to the driver, row r is data[8r+7:8r]
//   oe             registered driver output enable
module matrix_frame_ctrl #(
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [2:0]  wr_row,
    input  logic [7:0]  wr_data,
    input  logic        commit,
    output logic        commit_pending,
    output logic        swap_done,
    input  logic        enable,
    input  logic        blink_en,
    output logic [63:0] data,
    output logic        oe
);

    localparam logic [15:0] LastFrame = 16'(BLINK_FRAMES - 1);

    logic [63:0] back_q, back_d;
    logic [63:0] front_q, front_d;
    logic [2:0]  phase_q, phase_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        blink_on_q, blink_on_d;
    logic        pend_q, pend_d;
    logic        oe_q, oe_d;
    logic        swap_done_q, swap_done_d;

    logic       wr_fire;
    logic       frame_end;
    logic       copy;
    logic [5:0] wr_lsb;

    assign wr_fire   = wr_valid && !pend_q;
    assign wr_lsb    = {wr_row, 3'b000};
    // phase mirrors the driver's row counter, so phase 7 with oe high is the
    // last row of a frame.
    assign frame_end = oe_q && (phase_q == 3'd7);
    // With the driver idle there is no frame to tear, so copy immediately.
    assign copy      = pend_q && (frame_end || !oe_q);

    always_comb begin
        back_d      = back_q;
        front_d     = front_q;
        pend_d      = pend_q;
        frame_cnt_d = frame_cnt_q;
        blink_on_d  = blink_on_q;
        phase_d     = oe_q ? phase_q + 3'd1 : 3'd0;
        oe_d        = enable;
        swap_done_d = copy;

        if (wr_fire) begin
            back_d[wr_lsb +: 8] = wr_data;
        end

        if (copy) begin
            front_d = back_q;
            pend_d  = 1'b0;
        end else if (commit) begin
            // copy needs pend_q, so reaching here with pend_q high means the
            // commit arrived while one was pending and is dropped.
            pend_d = 1'b1;
        end

        if (!blink_en) begin
            frame_cnt_d = 16'd0;
            blink_on_d  = 1'b1;
        end else if (frame_end) begin
            if (frame_cnt_q == LastFrame) begin
                frame_cnt_d = 16'd0;
                blink_on_d  = !blink_on_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            back_q      <= 64'd0;
            front_q     <= 64'd0;
            phase_q     <= 3'd0;
            frame_cnt_q <= 16'd0;
            blink_on_q  <= 1'b1;
            pend_q      <= 1'b0;
            oe_q        <= 1'b0;
            swap_done_q <= 1'b0;
        end else begin
            back_q      <= back_d;
            front_q     <= front_d;
            phase_q     <= phase_d;
            frame_cnt_q <= frame_cnt_d;
            blink_on_q  <= blink_on_d;
            pend_q      <= pend_d;
            oe_q        <= oe_d;
            swap_done_q <= swap_done_d;
        end
    end

    assign wr_ready       = !pend_q;
    assign commit_pending = pend_q;
    assign swap_done      = swap_done_q;
    assign oe             = oe_q;
    // Blink blanks the data rather than oe so the driver's row scan keeps running.
    assign data           = blink_on_q ? front_q : 64'd0;

endmodule
